otp_bank_sched: RTL and testbench

- Schedules the RAM bank ring shared by the OTP generator (producer) and the SD datapath (consumer). Runs in the oclk_sd domain; producer handshakes cross to clk_otp domain through external synchronisers.
- Tells the producer which bank to fill next, and grants filled banks to the consumer in FIFO order.
- Never lets a bank be overwritten before the consumer has released it.
- Replaces free-running whole-buffer generation with per-bank flow control.

---
 rtl/otp_bank_sched.sv | 135 +++++++++++++
 tb/tb_otp_bank_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_bank_sched.sv
`default_nettype none
// ============================================================================
// otp_bank_sched : flow-controlled bank ring between OTP producer and SD consumer
// Rev 1.0
// ============================================================================
module otp_bank_sched #(
  parameter  int RAM_BLOCKS = 8,
  localparam int SEL_W      = $clog2(RAM_BLOCKS)
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             ienable,
  output logic             ogen_start,
  output logic [SEL_W-1:0] ogen_sel,
  input  logic             igen_done,
  input  logic             ireq,
  output logic             ogrant,
  output logic [SEL_W-1:0] ogrant_sel,
  input  logic             irelease,
  output logic [SEL_W:0]   ocount,
  output logic             obusy,
  output logic             oerror
);

  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
  localparam logic [SEL_W:0]   CNT_ONE = (SEL_W + 1)'(1);
  localparam logic [SEL_W:0]   FULL    = (SEL_W + 1)'(RAM_BLOCKS);

  typedef enum logic [0:0] {P_IDLE = 1'b0, P_WAIT = 1'b1} prod_e;
  typedef enum logic [0:0] {C_IDLE = 1'b0, C_HOLD = 1'b1} cons_e;

  prod_e            p_q, p_d;
  cons_e            c_q, c_d;
  logic [SEL_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [SEL_W-1:0] gen_sel_q, gen_sel_d, grant_sel_q, grant_sel_d;
  logic [SEL_W:0]   count_q, count_d;
  logic             start_q, start_d, grant_q, grant_d;
  logic             busy_q, busy_d, err_q, err_d;
  logic             fill_done, bank_rel, clr;

  always_comb begin
    p_d         = p_q;
    c_d         = c_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    gen_sel_d   = gen_sel_q;
    grant_sel_d = grant_sel_q;
    count_d     = count_q;
    start_d     = 1'b0;
    grant_d     = 1'b0;
    fill_done   = (p_q == P_WAIT) && igen_done;
    bank_rel    = (c_q == C_HOLD) && irelease;
    clr         = 1'b0;

    case (p_q)
      P_IDLE: if (ienable && (count_q < FULL)) begin
        p_d       = P_WAIT;
        start_d   = 1'b1;
        gen_sel_d = wp_q;
      end
      default: if (igen_done) begin
        p_d  = P_IDLE;
        wp_d = wp_q + SEL_ONE;
      end
    endcase

    case (c_q)
      C_IDLE: if (ireq && (count_q != '0)) begin
        c_d         = C_HOLD;
        grant_d     = 1'b1;
        grant_sel_d = rp_q;
      end
      default: if (irelease) begin
        c_d  = C_IDLE;
        rp_d = rp_q + SEL_ONE;
      end
    endcase

    if (fill_done && !bank_rel) begin
      count_d = count_q + CNT_ONE;
    end else if (bank_rel && !fill_done) begin
      count_d = count_q - CNT_ONE;
    end

    err_d = err_q | ((p_q == P_IDLE) && igen_done) | ((c_q == C_IDLE) && irelease);

    // A grant issued on the same edge wins over the clear so a stopped session can still drain.
    clr = !ienable && (p_q == P_IDLE) && (c_q == C_IDLE) && !igen_done && !irelease && !grant_d;
    if (clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end

    busy_d = (p_d == P_WAIT) || (c_d == C_HOLD);
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      p_q         <= P_IDLE;
      c_q         <= C_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      gen_sel_q   <= '0;
      grant_sel_q <= '0;
      count_q     <= '0;
      start_q     <= 1'b0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      p_q         <= p_d;
      c_q         <= c_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      gen_sel_q   <= gen_sel_d;
      grant_sel_q <= grant_sel_d;
      count_q     <= count_d;
      start_q     <= start_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign ogen_start = start_q;
  assign ogen_sel   = gen_sel_q;
  assign ogrant     = grant_q;
  assign ogrant_sel = grant_sel_q;
  assign ocount     = count_q;
  assign obusy      = busy_q;
  assign oerror     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_otp_bank_sched.sv
`default_nettype none
// ============================================================================
// tb_otp_bank_sched : scoreboard bench for the bank-ring scheduler
// Rev 1.0
// ============================================================================
module tb_otp_bank_sched;

  logic       iclk;
  logic       irst_n;
  logic       ienable;
  logic       ogen_start;
  logic [2:0] ogen_sel;
  logic       igen_done;
  logic       ireq;
  logic       ogrant;
  logic [2:0] ogrant_sel;
  logic       irelease;
  logic [3:0] ocount;
  logic       obusy;
  logic       oerror;

  logic auto_done, man_done, auto_rel, man_rel;
  logic prod_auto, cons_auto;
  int   prod_delay, rel_delay;
  int   tests, fails;
  int   exp_gen[$];
  int   exp_grant[$];
  int   mon_e;

  assign igen_done = auto_done | man_done;
  assign irelease  = auto_rel | man_rel;

  otp_bank_sched #(.RAM_BLOCKS(8)) dut (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .ienable   (ienable),
    .ogen_start(ogen_start),
    .ogen_sel  (ogen_sel),
    .igen_done (igen_done),
    .ireq      (ireq),
    .ogrant    (ogrant),
    .ogrant_sel(ogrant_sel),
    .irelease  (irelease),
    .ocount    (ocount),
    .obusy     (obusy),
    .oerror    (oerror)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every start/grant pulse must match the head of its queue.
  always @(negedge iclk) begin
    if (ogen_start) begin
      tests++;
      if (exp_gen.size() == 0) begin
        fails++;
        $display("FAIL gen_start: got unexpected start sel=%0d, expected no start", ogen_sel);
      end else begin
        mon_e = exp_gen.pop_front();
        if (ogen_sel !== mon_e[2:0]) begin
          fails++;
          $display("FAIL gen_sel: got %0d, expected %0d", ogen_sel, mon_e);
        end
      end
    end
    if (ogrant) begin
      tests++;
      if (exp_grant.size() == 0) begin
        fails++;
        $display("FAIL grant: got unexpected grant sel=%0d, expected no grant", ogrant_sel);
      end else begin
        mon_e = exp_grant.pop_front();
        if (ogrant_sel !== mon_e[2:0] || ocount == 4'd0) begin
          fails++;
          $display("FAIL grant_sel: got sel %0d count %0d, expected sel %0d count >0",
                   ogrant_sel, ocount, mon_e);
        end
      end
    end
  end

  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge iclk);
      auto_done = 1'b0;
      if (prod_auto && ogen_start) begin
        repeat (prod_delay) @(negedge iclk);
        auto_done = prod_auto;
      end
    end
  end

  initial begin
    auto_rel = 1'b0;
    forever begin
      @(negedge iclk);
      auto_rel = 1'b0;
      if (cons_auto && ogrant) begin
        repeat (rel_delay) @(negedge iclk);
        auto_rel = cons_auto;
      end
    end
  end

  task automatic wait_start();
    int k;
    k = 0;
    while (!ogen_start && k < 100) begin
      @(negedge iclk);
      k++;
    end
    check("start_timeout", {31'd0, ogen_start}, 32'd1);
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (!ogrant && k < 100) begin
      @(negedge iclk);
      k++;
    end
    check("grant_timeout", {31'd0, ogrant}, 32'd1);
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    @(negedge iclk);
    man_done = 1'b0;
  endtask

  task automatic pulse_rel();
    man_rel = 1'b1;
    @(negedge iclk);
    man_rel = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    irst_n = 1'b0; ienable = 1'b0; ireq = 1'b0;
    man_done = 1'b0; man_rel = 1'b0;
    prod_auto = 1'b0; cons_auto = 1'b0;
    prod_delay = 4; rel_delay = 2;

    repeat (3) @(negedge iclk);
    check("reset_outputs", {18'd0, ogen_start, ogen_sel, ogrant, ogrant_sel, ocount, obusy, oerror}, 32'd0);
    irst_n = 1'b1;

    // Fill the whole ring with a slow producer; no ninth start allowed.
    for (int i = 0; i < 8; i++) exp_gen.push_back(i);
    prod_auto = 1'b1;
    ienable   = 1'b1;
    for (int k = 0; k < 200 && ocount != 4'd8; k++) @(negedge iclk);
    check("t1_full", ocount, 32'd8);
    repeat (50) @(negedge iclk);
    check("t1_starts_left", exp_gen.size(), 32'd0);
    check("t1_count_hold", ocount, 32'd8);

    // Consume bank 0 from the full ring, then the freed slot refills with wrap.
    exp_grant.push_back(0);
    ireq = 1'b1;
    wait_grant();
    ireq = 1'b0;
    check("t2_held_counted", ocount, 32'd8);
    check("t2_busy", {31'd0, obusy}, 32'd1);
    exp_gen.push_back(0);
    pulse_rel();
    check("t2_after_release", ocount, 32'd7);
    wait_start();
    for (int k = 0; k < 50 && ocount != 4'd8; k++) @(negedge iclk);
    check("t2_refull", ocount, 32'd8);

    // Stop the session with everything idle: ring clears.
    ienable = 1'b0;
    repeat (3) @(negedge iclk);
    check("t2_cleared", ocount, 32'd0);
    check("t2_idle", {31'd0, obusy}, 32'd1 - 32'd1);

    // Streaming: immediate producer, consumer holding 2 cycles, ireq high.
    prod_delay = 0;
    rel_delay  = 2;
    cons_auto  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_gen.push_back(i % 8);
      exp_grant.push_back(i % 8);
    end
    ireq    = 1'b1;
    ienable = 1'b1;
    for (int k = 0; k < 300 && exp_gen.size() != 0; k++) @(negedge iclk);
    ienable = 1'b0;
    for (int k = 0; k < 300 && !(exp_grant.size() == 0 && ocount == 4'd0 && !obusy); k++)
      @(negedge iclk);
    check("t3_drained_grants", exp_grant.size(), 32'd0);
    check("t3_drained_count", ocount, 32'd0);
    ireq      = 1'b0;
    cons_auto = 1'b0;
    prod_auto = 1'b0;
    repeat (2) @(negedge iclk);

    // Three manual fills, a fourth in flight, then done+release on one edge.
    for (int i = 0; i < 5; i++) exp_gen.push_back(i);
    ienable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_start();
      pulse_done();
    end
    wait_start();
    check("t4_count3", ocount, 32'd3);
    exp_grant.push_back(0);
    ireq = 1'b1;
    wait_grant();
    ireq = 1'b0;
    man_done = 1'b1;
    man_rel  = 1'b1;
    @(negedge iclk);
    man_done = 1'b0;
    man_rel  = 1'b0;
    check("t4_simul_count", ocount, 32'd3);
    exp_grant.push_back(1);
    ireq = 1'b1;
    wait_start();
    wait_grant();
    ireq = 1'b0;

    // Session stop while a fill is in flight: it completes and the ring drains.
    pulse_rel();
    ienable = 1'b0;
    check("t5_before_fill", ocount, 32'd2);
    for (int i = 2; i < 5; i++) exp_grant.push_back(i);
    rel_delay = 1;
    cons_auto = 1'b1;
    ireq      = 1'b1;
    pulse_done();
    check("t5_inflight_done", ocount, 32'd3);
    for (int k = 0; k < 100 && !(exp_grant.size() == 0 && ocount == 4'd0 && !obusy); k++)
      @(negedge iclk);
    check("t5_drained_grants", exp_grant.size(), 32'd0);
    check("t5_drained_count", ocount, 32'd0);
    ireq      = 1'b0;
    cons_auto = 1'b0;
    repeat (2) @(negedge iclk);
    exp_gen.push_back(0);
    ienable = 1'b1;
    wait_start();

    // Stray release sets the sticky error; the ring then clears as normal.
    ienable  = 1'b0;
    man_done = 1'b1;
    @(negedge iclk);
    man_done = 1'b0;
    check("t6_one_filled", ocount, 32'd1);
    check("t6_no_error_yet", {31'd0, oerror}, 32'd0);
    pulse_rel();
    check("t6_error_set", {31'd0, oerror}, 32'd1);
    check("t6_count_kept", ocount, 32'd1);
    @(negedge iclk);
    check("t6_cleared", ocount, 32'd0);
    check("t6_error_sticky", {31'd0, oerror}, 32'd1);

    // Reset in the middle of a fill.
    exp_gen.push_back(0);
    ienable = 1'b1;
    wait_start();
    irst_n  = 1'b0;
    ienable = 1'b0;
    @(negedge iclk);
    check("t7_reset_outputs", {18'd0, ogen_start, ogen_sel, ogrant, ogrant_sel, ocount, obusy, oerror}, 32'd0);
    irst_n = 1'b1;
    repeat (10) @(negedge iclk);
    check("t7_post_reset", {27'd0, ocount, oerror}, 32'd0);
    exp_gen.push_back(0);
    ienable = 1'b1;
    wait_start();
    ienable = 1'b0;
    repeat (3) @(negedge iclk);
    check("final_gen_queue", exp_gen.size(), 32'd0);
    check("final_grant_queue", exp_grant.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
